// File: rtl/quad_track_array.sv
// Multi-channel quadrature trackball/spinner counter array: two-flop synchronisers,
// per-channel glitch filter, Gray-code step decode and a registered read-and-clear port.
module quad_track_array #(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int FILT = 3,
    parameter int SAT  = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     ce,
    input  logic [NCH-1:0]                           qa,
    input  logic [NCH-1:0]                           qb,
    input  logic [NCH-1:0]                           invert,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] addr,
    input  logic                                     rd,
    input  logic                                     clr,
    output logic [CW-1:0]                            data,
    output logic [NCH-1:0]                           dir,
    output logic [NCH-1:0]                           err
);

    localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CWP = CW + 2;
    localparam logic [2:0] FILT_R = 3'(FILT);
    localparam logic signed [CW+1:0] CMAX = CWP'((1 << CW) - 1);

    function automatic logic [CW-1:0] wrap_cnt(input logic signed [CW+1:0] sum);
        return sum[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] sat_cnt(input logic signed [CW+1:0] sum);
        if (sum[CW+1]) return '0;
        if (sum > CMAX) return '1;
        return sum[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cur, input logic dec);
        logic signed [CW+1:0] delta;
        logic signed [CW+1:0] sum;
        delta = dec ? '1 : CWP'(1);
        sum   = $signed({2'b00, cur}) + delta;
        return (SAT != 0) ? sat_cnt(sum) : wrap_cnt(sum);
    endfunction

    // Returns {legal, reverse} for an {A,B} transition; both bits changing is illegal.
    function automatic logic [1:0] decode(input logic [1:0] old_s, input logic [1:0] new_s);
        case ({old_s, new_s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return 2'b10;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: return 2'b11;
            default:                                return 2'b00;
        endcase
    endfunction

    logic [NCH-1:0] qa_p0, qb_p0, qa_p1, qb_p1;
    logic [1:0]     cand_p2 [NCH];
    logic [2:0]     run_p2  [NCH];
    logic [1:0]     acc_p2  [NCH];
    logic [NCH-1:0] init_p2;
    logic [CW-1:0]  cnt_p2  [NCH];

    logic [1:0]     smp_nx  [NCH];
    logic [1:0]     dc_nx   [NCH];
    logic [1:0]     cand_nx [NCH];
    logic [2:0]     run_nx  [NCH];
    logic [CW-1:0]  cnt_nx  [NCH];
    logic [NCH-1:0] vld_p2, step_en, err_set, dec_nx, clr_hit;
    logic [CW-1:0]  rd_val;

    // Stage p2: filter advance, acceptance, decode and read mux
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NCH; i++) begin
            smp_nx[i]  = {qa_p1[i], qb_p1[i]};
            cand_nx[i] = cand_p2[i];
            run_nx[i]  = run_p2[i];
            if (ce) begin
                if (smp_nx[i] == cand_p2[i]) begin
                    if (run_p2[i] != FILT_R) run_nx[i] = run_p2[i] + 3'd1;
                end else begin
                    cand_nx[i] = smp_nx[i];
                    run_nx[i]  = 3'd1;
                end
            end
            // While init is set the first full run is accepted even if it matches.
            vld_p2[i]  = ce && (run_nx[i] == FILT_R) &&
                         (init_p2[i] || (cand_nx[i] != acc_p2[i]));
            dc_nx[i]   = decode(acc_p2[i], cand_nx[i]);
            step_en[i] = vld_p2[i] && !init_p2[i] && dc_nx[i][1];
            err_set[i] = vld_p2[i] && !init_p2[i] && !dc_nx[i][1];
            dec_nx[i]  = dc_nx[i][0] ^ invert[i];
            cnt_nx[i]  = next_cnt(cnt_p2[i], dec_nx[i]);
            clr_hit[i] = clr && (addr == AW'(i));
            if (addr == AW'(i)) rd_val = cnt_p2[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qa_p0   <= '0;
            qb_p0   <= '0;
            qa_p1   <= '0;
            qb_p1   <= '0;
            init_p2 <= '1;
            data    <= '0;
            dir     <= '0;
            err     <= '0;
            for (int i = 0; i < NCH; i++) begin
                cand_p2[i] <= '0;
                run_p2[i]  <= '0;
                acc_p2[i]  <= '0;
                cnt_p2[i]  <= '0;
            end
        end else begin
            // Stage p0/p1: two-flop synchroniser
            qa_p0 <= qa;
            qb_p0 <= qb;
            qa_p1 <= qa_p0;
            qb_p1 <= qb_p0;
            // Stage p2: filter state, counters, flags and read register
            if (rd) data <= rd_val;
            for (int i = 0; i < NCH; i++) begin
                cand_p2[i] <= cand_nx[i];
                run_p2[i]  <= run_nx[i];
                if (vld_p2[i]) begin
                    acc_p2[i]  <= cand_nx[i];
                    init_p2[i] <= 1'b0;
                end
                if (step_en[i]) dir[i] <= dec_nx[i];
                if (clr_hit[i]) begin
                    cnt_p2[i] <= '0;
                    err[i]    <= 1'b0;
                end else begin
                    if (step_en[i]) cnt_p2[i] <= cnt_nx[i];
                    if (err_set[i]) err[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_track_array.sv
// Bench for quad_track_array: two instances (wrap and saturate) checked every cycle
// against a sample-history model, plus directed scenarios with literal expectations.
module tb_quad_track_array;

    localparam int N0 = 4, F0 = 3;
    localparam int N1 = 3, F1 = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          ce    = 1'b1;
    logic [N0-1:0] qa0 = '0, qb0 = '0, inv0 = '0;
    logic [1:0]    addr0 = '0;
    logic          rd0 = 1'b0, clr0 = 1'b0;
    logic [7:0]    data0;
    logic [N0-1:0] dir0, err0;
    logic [N1-1:0] qa1 = '0, qb1 = '0, inv1 = '0;
    logic [1:0]    addr1 = '0;
    logic          rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0]    data1;
    logic [N1-1:0] dir1, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_track_array #(.NCH(N0), .CW(8), .FILT(F0), .SAT(0)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .qa(qa0), .qb(qb0), .invert(inv0),
        .addr(addr0), .rd(rd0), .clr(clr0), .data(data0), .dir(dir0), .err(err0));

    quad_track_array #(.NCH(N1), .CW(8), .FILT(F1), .SAT(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .qa(qa1), .qb(qb1), .invert(inv1),
        .addr(addr1), .rd(rd1), .clr(clr1), .data(data1), .dir(dir1), .err(err1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: accepted value = last FILT ce-samples of the synced pins, all equal.
    int       m_cnt  [2][8];
    bit [1:0] m_d1   [2][8];
    bit [1:0] m_d2   [2][8];
    bit [1:0] m_acc  [2][8];
    bit [1:0] m_hist [2][8][8];
    int       m_hn   [2][8];
    bit       m_init [2][8];
    bit       m_dir  [2][8];
    bit       m_err  [2][8];
    int       m_data [2];

    function automatic int gidx(input bit [1:0] v);
        return int'({v[1], v[1] ^ v[0]});
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 0;
            for (int c = 0; c < 8; c++) begin
                m_cnt[k][c] = 0;  m_d1[k][c] = 0;  m_d2[k][c] = 0;  m_acc[k][c] = 0;
                m_hn[k][c]  = 0;  m_init[k][c] = 1; m_dir[k][c] = 0; m_err[k][c] = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input logic [7:0] pa, input logic [7:0] pb,
                              input logic [7:0] inv, input int ad, input logic r, input logic cl);
        int nch, f, rv, d, st, nc;
        bit [1:0] s;
        bit all;
        nch = (k == 0) ? N0 : N1;
        f   = (k == 0) ? F0 : F1;
        rv  = (ad < nch) ? m_cnt[k][ad] : 0;
        for (int c = 0; c < nch; c++) begin
            s = m_d2[k][c];
            m_d2[k][c] = m_d1[k][c];
            m_d1[k][c] = {pa[c], pb[c]};
            if (ce) begin
                for (int j = 7; j > 0; j--) m_hist[k][c][j] = m_hist[k][c][j-1];
                m_hist[k][c][0] = s;
                if (m_hn[k][c] < f) m_hn[k][c]++;
                all = (m_hn[k][c] == f);
                for (int j = 0; j < f; j++) if (m_hist[k][c][j] != s) all = 0;
                if (all && (m_init[k][c] || s != m_acc[k][c])) begin
                    if (m_init[k][c]) m_init[k][c] = 0;
                    else begin
                        d = (gidx(s) - gidx(m_acc[k][c])) & 3;
                        if (d == 2) m_err[k][c] = 1;
                        else begin
                            st = (d == 1) ? 1 : -1;
                            if (inv[c]) st = -st;
                            m_dir[k][c] = (st < 0);
                            nc = m_cnt[k][c] + st;
                            if (k == 1) nc = (nc < 0) ? 0 : ((nc > 255) ? 255 : nc);
                            else nc = nc & 255;
                            m_cnt[k][c] = nc;
                        end
                    end
                    m_acc[k][c] = s;
                end
            end
            if (cl && ad == c) begin
                m_cnt[k][c] = 0;
                m_err[k][c] = 0;
            end
        end
        if (r) m_data[k] = rv;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else begin
            model_step(0, 8'(qa0), 8'(qb0), 8'(inv0), int'(addr0), rd0, clr0);
            model_step(1, 8'(qa1), 8'(qb1), 8'(inv1), int'(addr1), rd1, clr1);
        end
    end

    function automatic logic [7:0] mvec(input int k, input int sel);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[c] = (sel == 0) ? m_dir[k][c] : m_err[k][c];
        return v;
    endfunction

    always @(negedge clk) begin
        chk("u0.data", data0, m_data[0]);
        chk("u0.dir",  dir0,  mvec(0, 0));
        chk("u0.err",  err0,  mvec(0, 1));
        chk("u1.data", data1, m_data[1]);
        chk("u1.dir",  dir1,  mvec(1, 0));
        chk("u1.err",  err1,  mvec(1, 1));
    end

    // Directed helpers, all entered right after a falling edge.
    int ph [2][8];

    function automatic logic [1:0] gcode(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic set_pins(input int k, input int c, input logic [1:0] v);
        if (k == 0) begin qa0[c] = v[1]; qb0[c] = v[0]; end
        else        begin qa1[c] = v[1]; qb1[c] = v[0]; end
    endtask

    task automatic step(input int k, input int c, input int d, input int n);
        ph[k][c] = (ph[k][c] + d) & 3;
        set_pins(k, c, gcode(ph[k][c]));
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_check(input int k, input int a, input int expv, input string nm);
        if (k == 0) begin addr0 = 2'(a); rd0 = 1'b1; end
        else        begin addr1 = 2'(a); rd1 = 1'b1; end
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
        chk(nm, (k == 0) ? data0 : data1, expv);
    endtask

    task automatic clr_ch(input int k, input int a);
        if (k == 0) begin addr0 = 2'(a); clr0 = 1'b1; end
        else        begin addr1 = 2'(a); clr1 = 1'b1; end
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        #1 reset = 1'b1;
        qa0[0] = 1'b1;
        qb0[0] = 1'b1;
        ph[0][0] = 2;
        repeat (3) @(negedge clk);
        chk("rst.data0", data0, 0);
        chk("rst.dir0", dir0, 0);
        chk("rst.err0", err0, 0);
        chk("rst.data1", data1, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        rd_check(0, 0, 0, "init.cnt0");
        chk("init.err0", err0, 0);

        for (int i = 0; i < 16; i++) step(0, 1, 1, 6);
        rd_check(0, 1, 16, "fwd16");
        chk("fwd.dir1", dir0[1], 0);
        for (int i = 0; i < 3; i++) step(0, 1, -1, 6);
        rd_check(0, 1, 13, "rev13");
        chk("rev.dir1", dir0[1], 1);
        step(0, 1, -1, 6);
        inv0[1] = 1'b1;
        clr_ch(0, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 6);
        rd_check(0, 1, 240, "inv240");
        chk("inv.dir1", dir0[1], 1);
        inv0[1] = 1'b0;

        step(0, 2, -1, 6);
        rd_check(0, 2, 255, "wrap.dn");
        step(0, 2, 1, 6);
        rd_check(0, 2, 0, "wrap.up");

        qa0[3] = 1'b1;
        repeat (2) @(negedge clk);
        qa0[3] = 1'b0;
        repeat (8) @(negedge clk);
        rd_check(0, 3, 0, "glitch.cnt");
        chk("glitch.err", err0[3], 0);
        step(0, 3, 1, 0);
        addr0 = 2'd3;
        rd0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("lat.k4", data0, 0);
        @(negedge clk);
        chk("lat.k5", data0, 1);
        rd0 = 1'b0;

        step(0, 0, 1, 6);
        step(0, 0, 1, 6);
        clr_ch(0, 0);
        set_pins(0, 0, 2'b11);
        ph[0][0] = 2;
        repeat (6) @(negedge clk);
        chk("ill.err0", err0[0], 1);
        rd_check(0, 0, 0, "ill.cnt0");
        repeat (10) @(negedge clk);
        chk("ill.sticky", err0[0], 1);
        clr_ch(0, 0);
        chk("ill.clr", err0[0], 0);

        clr_ch(0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 6);
        step(0, 1, 1, 0);
        set_pins(0, 0, 2'b00);
        ph[0][0] = 0;
        step(0, 2, -1, 0);
        repeat (4) @(negedge clk);
        addr0 = 2'd1;
        rd0 = 1'b1;
        clr0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        clr0 = 1'b0;
        chk("race.data", data0, 7);
        chk("race.err0", err0[0], 1);
        chk("race.dir2", dir0[2], 1);
        rd_check(0, 1, 0, "race.cnt1");

        step(1, 0, -1, 4);
        rd_check(1, 0, 0, "sat.lo");
        chk("sat.lo.dir", dir1[0], 1);
        for (int i = 0; i < 256; i++) step(1, 0, 1, 4);
        rd_check(1, 0, 255, "sat.hi");
        chk("sat.hi.dir", dir1[0], 0);
        rd_check(1, 3, 0, "oor.rd");
        clr_ch(1, 3);
        rd_check(1, 0, 255, "oor.clr");

        for (int cyc = 0; cyc < 4000; cyc++) begin
            ce = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N0; c++)
                if ($urandom_range(0, 7) == 0) begin
                    v = 2'($urandom);
                    qa0[c] = v[1];
                    qb0[c] = v[0];
                end
            for (int c = 0; c < N1; c++)
                if ($urandom_range(0, 7) == 0) begin
                    v = 2'($urandom);
                    qa1[c] = v[1];
                    qb1[c] = v[0];
                end
            if ($urandom_range(0, 99) == 0) inv0 = N0'($urandom);
            if ($urandom_range(0, 99) == 0) inv1 = N1'($urandom);
            addr0 = 2'($urandom);
            addr1 = 2'($urandom);
            rd0  = ($urandom_range(0, 2) == 0);
            rd1  = ($urandom_range(0, 2) == 0);
            clr0 = ($urandom_range(0, 15) == 0);
            clr1 = ($urandom_range(0, 15) == 0);
            #1 reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        rd0 = 1'b0;
        rd1 = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
